bht_btb_pred_stage: RTL

//  Registered, parametrised successor of the BHT/BTB decode step in the fetch frontend.
//  - Scans one fetch block's saturating counters from the fetch-PC slot upward.
//  - Picks the first predicted-taken slot and forms trigger PC and target.
//  - Sits between the BHT/BTB SRAM read and the fetch redirect.
//  - One-entry output pipeline register, valid/ready handshake, flush.

---
 rtl/bht_btb_pred_stage_pkg.sv | 27 ++
 rtl/bht_btb_pred_stage_first_taken.sv | 31 +++
 rtl/bht_btb_pred_stage.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bht_btb_pred_stage_pkg.sv
// Shared geometry, record type and counter helper for the BHT/BTB prediction stage.
// Default geometry: 16 slots, 2-bit counters, 64-bit PC, 32-bit BTB target, 4-byte slots.
package pred_pkg;

    localparam int DEF_SLOTS      = 16;
    localparam int DEF_CNT_W      = 2;
    localparam int DEF_PC_W       = 64;
    localparam int DEF_TGT_W      = 32;
    localparam int DEF_INST_BYTES = 4;

    localparam int SLOT_IW = $clog2(DEF_SLOTS);
    localparam int OFF_LSB = $clog2(DEF_INST_BYTES);

    typedef struct packed {
        logic [DEF_PC_W-1:0] pc;
        logic                taken;
        logic [SLOT_IW-1:0]  slot;
        logic [DEF_PC_W-1:0] trigger_pc;
        logic [DEF_PC_W-1:0] target;
    } pred_rec_t;

    // A counter predicts taken when its most significant bit is set.
    function automatic logic cnt_taken(input logic [DEF_CNT_W-1:0] cnt);
        return cnt[DEF_CNT_W-1];
    endfunction

endpackage

// File: rtl/bht_btb_pred_stage_first_taken.sv
// Masked priority picker: lowest slot at or above the start slot whose counter MSB is set.
module pred_first_taken
    import pred_pkg::*;
#(
    parameter int SLOTS = DEF_SLOTS,
    parameter int CNT_W = DEF_CNT_W,
    localparam int SIW  = $clog2(SLOTS)
) (
    input  logic [SLOTS*CNT_W-1:0] cnt_i,
    input  logic [SIW-1:0]         s0_i,
    output logic                   found_o,
    output logic [SIW-1:0]         idx_o
);

    logic [CNT_W-1:0] c;

    // Scan from the top down so the last hit written is the lowest qualifying slot.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        c       = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            c = cnt_i[i*CNT_W +: CNT_W];
            if (SIW'(i) >= s0_i && c[CNT_W-1]) begin
                found_o = 1'b1;
                idx_o   = SIW'(i);
            end
        end
    end

endmodule

// File: rtl/bht_btb_pred_stage.sv
// BHT/BTB prediction stage: first-taken pick, trigger/target formation, one-entry output register.
// Optional PRED_STATS_EN adds saturating record/taken/tag-miss counters.
module bht_btb_pred_stage
    import pred_pkg::*;
#(
    parameter int SLOTS      = DEF_SLOTS,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int PC_W       = DEF_PC_W,
    parameter int TGT_W      = DEF_TGT_W,
    parameter int INST_BYTES = DEF_INST_BYTES,
    localparam int SIW       = $clog2(SLOTS),
    localparam int OFFL      = $clog2(INST_BYTES)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SLOTS*CNT_W-1:0] bht_rd_data,
    input  logic [TGT_W-1:0]       btb_rd_data,
    input  logic                   btbtag_hit,
    input  logic [PC_W-1:0]        fetch_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        out_pc,
    output logic                   out_taken,
    output logic [SIW-1:0]         out_slot,
    output logic [PC_W-1:0]        out_trigger_pc,
    output logic [PC_W-1:0]        out_target
`ifdef PRED_STATS_EN
    ,
    output logic [31:0]            stat_pred,
    output logic [31:0]            stat_taken,
    output logic [31:0]            stat_tagmiss
`endif
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [SIW-1:0]  slot;
        logic [PC_W-1:0] trigger_pc;
        logic [PC_W-1:0] target;
    } rec_t;

    logic [SIW-1:0] s0;
    logic           found;
    logic [SIW-1:0] idx;
    logic           accept;
    rec_t           rec_d, rec_q;
    logic           valid_d, valid_q;

    assign s0 = fetch_pc[OFFL +: SIW];

    pred_first_taken #(
        .SLOTS (SLOTS),
        .CNT_W (CNT_W)
    ) u_pick (
        .cnt_i   (bht_rd_data),
        .s0_i    (s0),
        .found_o (found),
        .idx_o   (idx)
    );

    // Handshake: a record moves in when in_valid && in_ready, where in_ready = !out_valid || out_ready;
    // the consumer takes it when out_valid && out_ready. Flush wins over acceptance.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        rec_d.pc         = fetch_pc;
        rec_d.taken      = found && btbtag_hit;
        rec_d.slot       = '0;
        rec_d.trigger_pc = '0;
        rec_d.target     = '0;
        if (rec_d.taken) begin
            rec_d.slot       = idx;
            rec_d.trigger_pc = fetch_pc + (PC_W'(idx - s0) << OFFL);
            rec_d.target     = PC_W'(btb_rd_data);
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            rec_q   <= '0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                rec_q <= rec_d;
            end
        end
    end

    assign out_valid      = valid_q;
    assign out_pc         = rec_q.pc;
    assign out_taken      = rec_q.taken;
    assign out_slot       = rec_q.slot;
    assign out_trigger_pc = rec_q.trigger_pc;
    assign out_target     = rec_q.target;

`ifdef PRED_STATS_EN
    logic [31:0] stat_pred_q, stat_taken_q, stat_tagmiss_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_pred_q    <= '0;
            stat_taken_q   <= '0;
            stat_tagmiss_q <= '0;
        end else if (accept) begin
            if (stat_pred_q != 32'hFFFF_FFFF) begin
                stat_pred_q <= stat_pred_q + 32'd1;
            end
            if (rec_d.taken && stat_taken_q != 32'hFFFF_FFFF) begin
                stat_taken_q <= stat_taken_q + 32'd1;
            end
            if (!btbtag_hit && stat_tagmiss_q != 32'hFFFF_FFFF) begin
                stat_tagmiss_q <= stat_tagmiss_q + 32'd1;
            end
        end
    end

    assign stat_pred    = stat_pred_q;
    assign stat_taken   = stat_taken_q;
    assign stat_tagmiss = stat_tagmiss_q;
`endif

endmodule
